// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage MIPS pipeline: load-use / branch-operand stalls, redirect flush, single-step freeze.
// Optional stall/flush performance counters are built when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl #(
   parameter int REG_AW       = 5,
   parameter int LD_BR_STALLS = 2,
   parameter int PERF_W       = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              run_en,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rt,
   input  logic              id_branch,
   input  logic              id_br_taken,
   input  logic              id_jump,
   input  logic              ex_memread,
   input  logic              ex_regwrite,
   input  logic [REG_AW-1:0] ex_wreg,
   input  logic              mem_memread,
   input  logic [REG_AW-1:0] mem_wreg,
   output logic              pipe_en,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              ifid_flush,
   output logic              idex_bubble,
   output logic              stalled,
   output logic [PERF_W-1:0] perf_stalls,
   output logic [PERF_W-1:0] perf_flushes
);

   typedef enum logic {
      Run   = 1'b0,
      Stall = 1'b1
   } stateT;

   localparam logic [1:0] LdBrN = 2'(LD_BR_STALLS);

   stateT      state_q, state_d;
   logic [1:0] scnt_q, scnt_d;
   logic       exSrc, memSrc;
   logic [1:0] hazN;

   // $0 is hard-wired zero, so a zero destination can never create a dependency
   assign exSrc  = (ex_wreg != '0) &&
                   ((ex_wreg == id_rs) || (id_uses_rt && (ex_wreg == id_rt)));
   assign memSrc = (mem_wreg != '0) &&
                   ((mem_wreg == id_rs) || (id_uses_rt && (mem_wreg == id_rt)));

   always_comb begin
      hazN = 2'd0;
      if (id_branch && ex_memread && exSrc) begin
         hazN = LdBrN;
      end else if (id_branch && ex_regwrite && exSrc) begin
         hazN = 2'd1;
      end else if (id_branch && mem_memread && memSrc) begin
         hazN = 2'd1;
      end else if (ex_memread && exSrc) begin
         hazN = 2'd1;
      end
   end

   // Output and next-state decode, in priority order: reset, freeze, stall, hazard, redirect, normal
   always_comb begin
      state_d     = state_q;
      scnt_d      = scnt_q;
      pipe_en     = 1'b1;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      stalled     = 1'b0;
      if (reset) begin
         state_d     = Run;
         scnt_d      = 2'd0;
         pipe_en     = 1'b0;
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (!run_en) begin
         pipe_en     = 1'b0;
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         stalled     = (state_q == Stall);
      end else if (state_q == Stall) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
         stalled     = 1'b1;
         scnt_d      = scnt_q - 2'd1;
         if (scnt_q == 2'd1) begin
            state_d = Run;
         end
      end else if (hazN != 2'd0) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
         if (hazN > 2'd1) begin
            state_d = Stall;
            scnt_d  = hazN - 2'd1;
         end
      end else if ((id_branch && id_br_taken) || id_jump) begin
         ifid_flush  = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
   end

`ifdef HAZARD_PERF_EN
   logic [PERF_W-1:0] perfStalls_q, perfFlushes_q;

   // Reset also drives bubble/flush high, but reset takes precedence and clears
   always_ff @(posedge clock) begin
      if (reset) begin
         perfStalls_q  <= '0;
         perfFlushes_q <= '0;
      end else if (run_en) begin
         if (idex_bubble) begin
            perfStalls_q <= perfStalls_q + 1'b1;
         end
         if (ifid_flush) begin
            perfFlushes_q <= perfFlushes_q + 1'b1;
         end
      end
   end

   assign perf_stalls  = perfStalls_q;
   assign perf_flushes = perfFlushes_q;
`else
   assign perf_stalls  = '0;
   assign perf_flushes = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed hazard scenarios followed by random traffic,
// all compared against a cycle-count reference model.
module tb_pipeline_hazard_ctrl;

   localparam int RegAw = 5;
   localparam int LdBr  = 2;
   localparam int PerfW = 32;

   logic             clock = 1'b0;
   logic             reset;
   logic             run_en;
   logic [RegAw-1:0] id_rs, id_rt, ex_wreg, mem_wreg;
   logic             id_uses_rt, id_branch, id_br_taken, id_jump;
   logic             ex_memread, ex_regwrite, mem_memread;
   logic             pipe_en, pc_write, ifid_write, ifid_flush, idex_bubble, stalled;
   logic [PerfW-1:0] perf_stalls, perf_flushes;

   int tests = 0;
   int fails = 0;

   // Reference model: remaining stall cycles after the current one, plus counter images
   int         remStall = 0;
   logic [PerfW-1:0] mPerfS = '0;
   logic [PerfW-1:0] mPerfF = '0;
   logic expPipe, expPc, expIfid, expFlush, expBubble, expStalled;

   pipeline_hazard_ctrl #(
      .REG_AW(RegAw), .LD_BR_STALLS(LdBr), .PERF_W(PerfW)
   ) dut (
      .clock(clock), .reset(reset), .run_en(run_en),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .id_branch(id_branch), .id_br_taken(id_br_taken), .id_jump(id_jump),
      .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_wreg(ex_wreg),
      .mem_memread(mem_memread), .mem_wreg(mem_wreg),
      .pipe_en(pipe_en), .pc_write(pc_write), .ifid_write(ifid_write),
      .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .stalled(stalled),
      .perf_stalls(perf_stalls), .perf_flushes(perf_flushes)
   );

   always #5 clock = ~clock;

   function automatic bit reads(input logic [RegAw-1:0] r);
      return (r != 0) && ((r == id_rs) || (id_uses_rt && (r == id_rt)));
   endfunction

   function automatic int stallsNeeded();
      if (id_branch && ex_memread && reads(ex_wreg)) return LdBr;
      if (id_branch && ex_regwrite && reads(ex_wreg)) return 1;
      if (id_branch && mem_memread && reads(mem_wreg)) return 1;
      if (ex_memread && reads(ex_wreg)) return 1;
      return 0;
   endfunction

   task automatic setOutputs(input logic p, input logic pc, input logic iw,
                             input logic fl, input logic bu, input logic st);
      expPipe = p; expPc = pc; expIfid = iw; expFlush = fl; expBubble = bu; expStalled = st;
   endtask

   task automatic modelEval();
      if (reset) setOutputs(0, 0, 0, 1, 1, 0);
      else if (!run_en) setOutputs(0, 0, 0, 0, 0, remStall > 0);
      else if (remStall > 0) setOutputs(1, 0, 0, 0, 1, 1);
      else if (stallsNeeded() > 0) setOutputs(1, 0, 0, 0, 1, 0);
      else if ((id_branch && id_br_taken) || id_jump) setOutputs(1, 1, 1, 1, 0, 0);
      else setOutputs(1, 1, 1, 0, 0, 0);
   endtask

   task automatic modelUpdate();
      if (reset) begin
         remStall = 0;
         mPerfS   = '0;
         mPerfF   = '0;
      end else if (run_en) begin
         if (expBubble) mPerfS = mPerfS + 1;
         if (expFlush)  mPerfF = mPerfF + 1;
         if (remStall > 0) remStall = remStall - 1;
         else if (stallsNeeded() > 1) remStall = stallsNeeded() - 1;
      end
   endtask

   task automatic checkVal(input string tag, input string name,
                           input logic [PerfW-1:0] got, input logic [PerfW-1:0] want);
      tests++;
      assert (got === want) else begin
         fails++;
         $error("[TB] FAIL %s %s got %0h want %0h", tag, name, got, want);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkVal(tag, "pipe_en",     PerfW'(pipe_en),     PerfW'(expPipe));
      checkVal(tag, "pc_write",    PerfW'(pc_write),    PerfW'(expPc));
      checkVal(tag, "ifid_write",  PerfW'(ifid_write),  PerfW'(expIfid));
      checkVal(tag, "ifid_flush",  PerfW'(ifid_flush),  PerfW'(expFlush));
      checkVal(tag, "idex_bubble", PerfW'(idex_bubble), PerfW'(expBubble));
      checkVal(tag, "stalled",     PerfW'(stalled),     PerfW'(expStalled));
`ifdef HAZARD_PERF_EN
      checkVal(tag, "perf_stalls",  perf_stalls,  mPerfS);
      checkVal(tag, "perf_flushes", perf_flushes, mPerfF);
`else
      checkVal(tag, "perf_stalls",  perf_stalls,  '0);
      checkVal(tag, "perf_flushes", perf_flushes, '0);
`endif
   endtask

   // One clock cycle: inputs already driven, check mid-cycle, then advance the model on the edge
   task automatic applyStimulus(input string tag);
      #3;
      modelEval();
      checkOutput(tag);
      @(posedge clock);
      modelUpdate();
      #1;
   endtask

   task automatic setIdle();
      reset = 0; run_en = 1;
      id_rs = 0; id_rt = 0; id_uses_rt = 0;
      id_branch = 0; id_br_taken = 0; id_jump = 0;
      ex_memread = 0; ex_regwrite = 0; ex_wreg = 0;
      mem_memread = 0; mem_wreg = 0;
   endtask

   task automatic loadBranch();
      setIdle();
      id_branch = 1; id_br_taken = 1; id_rs = 3; id_rt = 9; id_uses_rt = 1;
      ex_memread = 1; ex_regwrite = 1; ex_wreg = 9;
   endtask

   initial begin
      setIdle();
      reset = 1;
      @(posedge clock);
      #1;
      applyStimulus("reset0");
      applyStimulus("reset1");

      setIdle();
      applyStimulus("normal");

      setIdle(); ex_memread = 1; ex_regwrite = 1; ex_wreg = 8; id_rs = 8;
      applyStimulus("loaduse_bubble");
      setIdle(); mem_memread = 1; mem_wreg = 8; id_rs = 8;
      applyStimulus("loaduse_after");

      loadBranch();
      applyStimulus("ldbr_cyc1");
      applyStimulus("ldbr_cyc2");
      setIdle(); id_branch = 1; id_br_taken = 1; id_rt = 9; id_uses_rt = 1;
      applyStimulus("ldbr_flush");
      setIdle();
      applyStimulus("ldbr_after");

      setIdle(); ex_memread = 1; ex_wreg = 0; id_rs = 0;
      applyStimulus("zero_reg");

      setIdle(); id_branch = 1; id_rs = 4; ex_regwrite = 1; ex_wreg = 4;
      applyStimulus("br_alu_dep");
      setIdle(); id_branch = 1; id_rt = 6; id_uses_rt = 1; mem_memread = 1; mem_wreg = 6;
      applyStimulus("br_memload_dep");
      setIdle(); id_rt = 7; id_uses_rt = 0; ex_memread = 1; ex_wreg = 7;
      applyStimulus("rt_unused");

      loadBranch();
      applyStimulus("frz_hazard");
      run_en = 0;
      applyStimulus("frz_0");
      applyStimulus("frz_1");
      applyStimulus("frz_2");
      run_en = 1;
      applyStimulus("frz_resume_stall");
      setIdle();
      applyStimulus("frz_after");

      loadBranch();
      applyStimulus("rst_hazard");
      reset = 1;
      applyStimulus("rst_in_stall");
      setIdle();
      applyStimulus("rst_after");

      setIdle(); id_jump = 1;
      applyStimulus("jump");
      setIdle();
      applyStimulus("jump_after");

      for (int i = 0; i < 400; i++) begin
         reset       = ($urandom_range(0, 59) == 0);
         run_en      = ($urandom_range(0, 7) != 0);
         id_rs       = RegAw'($urandom_range(0, 3));
         id_rt       = RegAw'($urandom_range(0, 3));
         id_uses_rt  = 1'($urandom_range(0, 1));
         id_branch   = ($urandom_range(0, 2) == 0);
         id_br_taken = 1'($urandom_range(0, 1));
         id_jump     = ($urandom_range(0, 5) == 0);
         ex_memread  = 1'($urandom_range(0, 1));
         ex_regwrite = 1'($urandom_range(0, 1));
         ex_wreg     = RegAw'($urandom_range(0, 3));
         mem_memread = 1'($urandom_range(0, 1));
         mem_wreg    = RegAw'($urandom_range(0, 3));
         applyStimulus("random");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
